// File: rtl/lcd_dma_fetch.sv
// AHB INCR-burst read master for the LCD frame-buffer path: turns one fetch command
// (address, 1..MAXWORDS words) into bus reads and pushes each returned word to the pixel FIFO.
module lcd_dma_fetch #(
    parameter int MAXWORDS = 8
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        fetch,
    input  logic [31:0] faddr,
    input  logic [4:0]  fwords,
    output logic        dstrobe,
    output logic [31:0] fdata,
    output logic        done,
    output logic        err,
    output logic        HBUSREQ,
    input  logic        HGRANT,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP
);

    localparam int         CW         = $clog2(MAXWORDS + 1);
    localparam logic [1:0] HT_IDLE    = 2'b00;
    localparam logic [1:0] HT_NONSEQ  = 2'b10;
    localparam logic [1:0] HT_SEQ     = 2'b11;
    localparam logic [1:0] RSP_OKAY   = 2'b00;
    localparam logic [1:0] RSP_ERROR  = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [31:0]    r_addr;
    logic [31:0]    r_daddr;
    logic [CW-1:0]  r_acnt;
    logic [CW-1:0]  r_dcnt;
    logic           r_dph;
    logic           r_first;
    logic [1:0]     r_resp;
    logic           r_strobe;
    logic           r_done;
    logic           r_err;
    logic [31:0]    r_fdata;

    logic           w_busreq;
    logic [1:0]     w_trans;
    logic [CW-1:0]  w_nwords;
    logic           w_start;
    logic           w_zero;
    logic           w_accept;
    logic           w_dok;
    logic           w_resp1;
    logic           w_err_end;
    logic           w_retry_end;
    logic           w_last;

    assign w_nwords    = ({27'd0, fwords} > 32'(MAXWORDS)) ? CW'(MAXWORDS) : CW'(fwords);
    assign w_start     = (r_state == S_IDLE) && fetch && (fwords != 5'd0);
    assign w_zero      = (r_state == S_IDLE) && fetch && (fwords == 5'd0);
    // In XFER an address phase is always on the bus, so HREADY alone accepts it.
    assign w_accept    = (r_state == S_XFER) && HREADY;
    assign w_dok       = r_dph && HREADY && (HRESP == RSP_OKAY) && (r_state != S_RESP);
    assign w_resp1     = r_dph && !HREADY && (HRESP != RSP_OKAY) && (r_state != S_RESP);
    assign w_err_end   = (r_state == S_RESP) && HREADY && (r_resp == RSP_ERROR);
    assign w_retry_end = (r_state == S_RESP) && HREADY && (r_resp != RSP_ERROR);
    assign w_last      = w_dok && (r_dcnt == CW'(1));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_busreq = 1'b0;
        w_trans  = HT_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                w_busreq = 1'b1;
                if (w_resp1) begin
                    w_next = S_RESP;
                end else if (HGRANT && HREADY) begin
                    w_next = S_XFER;
                end
            end
            S_XFER: begin
                w_busreq = 1'b1;
                // Restart the burst after (re)grant and at every 1 KB boundary.
                w_trans  = (r_first || (r_addr[9:0] == 10'd0)) ? HT_NONSEQ : HT_SEQ;
                if (w_resp1) begin
                    w_next = S_RESP;
                end else if (HREADY && (r_acnt == CW'(1))) begin
                    w_next = S_DRAIN;
                end else if (HREADY && !HGRANT) begin
                    w_next = S_REQ;
                end
            end
            S_DRAIN: begin
                if (w_resp1) begin
                    w_next = S_RESP;
                end else if (w_last) begin
                    w_next = S_IDLE;
                end
            end
            S_RESP: begin
                if (HREADY) begin
                    w_next = (r_resp == RSP_ERROR) ? S_IDLE : S_REQ;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_addr  <= 32'd0;
            r_acnt  <= '0;
            r_dcnt  <= '0;
            r_dph   <= 1'b0;
            r_first <= 1'b0;
            r_resp  <= RSP_OKAY;
        end else begin
            if (w_start) begin
                r_addr <= faddr & 32'hFFFF_FFFC;
                r_acnt <= w_nwords;
                r_dcnt <= w_nwords;
            end else if (w_retry_end) begin
                // The failed beat never decremented dcnt, so it is reissued from its own address.
                r_addr <= r_daddr;
                r_acnt <= r_dcnt;
            end else if (w_err_end) begin
                r_acnt <= '0;
                r_dcnt <= '0;
            end else begin
                if (w_accept) begin
                    r_addr <= r_addr + 32'd4;
                    r_acnt <= r_acnt - CW'(1);
                end
                if (w_dok) begin
                    r_dcnt <= r_dcnt - CW'(1);
                end
            end
            if (HREADY) begin
                r_dph <= w_accept;
            end
            if ((r_state == S_REQ) && (w_next == S_XFER)) begin
                r_first <= 1'b1;
            end else if (w_accept) begin
                r_first <= 1'b0;
            end
            if (w_resp1) begin
                r_resp <= HRESP;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_accept) begin
            r_daddr <= r_addr;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_fdata  <= 32'd0;
        end else begin
            r_strobe <= w_dok;
            r_done   <= w_zero || w_last || w_err_end;
            r_err    <= w_err_end;
            if (w_dok) begin
                r_fdata <= HRDATA;
            end
        end
    end

    assign dstrobe = r_strobe;
    assign fdata   = r_fdata;
    assign done    = r_done;
    assign err     = r_err;
    assign HBUSREQ = w_busreq;
    assign HTRANS  = w_trans;
    assign HADDR   = r_addr;
    assign HWRITE  = 1'b0;
    assign HSIZE   = 3'b010;
    assign HBURST  = 3'b001;
    assign HWDATA  = 32'd0;

endmodule
